display_mmio_ctrl: RTL and testbench

Memory-mapped 4-digit 7-segment display controller at address 0x0001_0000, directly downstream of the address decoder. It receives the decoder's display write enable plus the CPU store data. On each write it:
- latches the stored word,
- converts it to BCD with a sequential shift-add-3 engine, saturating at 9999,
- drives a multiplexed, leading-zero-blanked display with a free-running digit scan.

---
 rtl/display_mmio_ctrl.sv | 164 ++++++++++++++++
 tb/tb_display_mmio_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/display_mmio_ctrl.sv
// Memory-mapped 4-digit 7-segment display controller: captures a CPU store,
// converts it to BCD with a shift-add-3 engine (saturating at 9999) and scans the digits.
module display_mmio_ctrl #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] value,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // state | meaning
  // IDLE  | display latch stable, waiting for a write (or a pending restart)
  // CONV  | 14 shift-add-3 iterations on {bcdReg, operand}
  // LOAD  | copy BCD result to display latch, or restart if a newer write arrived
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [13:0]    SAT      = 14'd9999;

  logic [1:0]    state;
  logic [3:0]    iterCnt;
  logic [15:0]   bcdReg;
  logic [13:0]   operand;
  logic [15:0]   dispLatch;
  logic          pending;
  logic [CW-1:0] refCnt;
  logic [1:0]    digitIdx;

  logic          newOvf;
  logic [13:0]   newOperand;
  logic [13:0]   reloadOperand;
  logic [15:0]   bcdAdj;

  function automatic logic [15:0] addThree(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign newOvf        = (wdata > 32'd9999);
  assign newOperand    = newOvf ? SAT : wdata[13:0];
  assign reloadOperand = ovf ? SAT : value[13:0];
  assign bcdAdj        = addThree(bcdReg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iterCnt   <= '0;
      bcdReg    <= '0;
      operand   <= '0;
      dispLatch <= '0;
      pending   <= 1'b0;
      value     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (we) begin
        value <= wdata;
        ovf   <= newOvf;
      end
      case (state)
        IDLE: begin
          if (we) begin
            state   <= CONV;
            bcdReg  <= '0;
            operand <= newOperand;
            iterCnt <= '0;
            pending <= 1'b0;
          end else if (pending) begin
            state   <= CONV;
            bcdReg  <= '0;
            operand <= reloadOperand;
            iterCnt <= '0;
            pending <= 1'b0;
          end
        end
        CONV: begin
          if (we) pending <= 1'b1;
          {bcdReg, operand} <= {bcdAdj, operand} << 1;
          iterCnt <= iterCnt + 4'd1;
          if (iterCnt == 4'd13) state <= LOAD;
        end
        LOAD: begin
          // A stale result is dropped so only the newest write ever reaches the display
          if (pending) begin
            state   <= CONV;
            bcdReg  <= '0;
            operand <= reloadOperand;
            iterCnt <= '0;
            pending <= we;
          end else begin
            dispLatch <= bcdReg;
            state     <= IDLE;
            pending   <= we;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refCnt   <= '0;
      digitIdx <= '0;
    end else if (refCnt == REF_LAST) begin
      refCnt   <= '0;
      digitIdx <= digitIdx + 2'd1;
    end else begin
      refCnt <= refCnt + CW'(1);
    end
  end

  logic [3:0] digit;
  logic       blank;
  logic [6:0] segRaw;
  logic       dpOn;

  always_comb begin
    digit  = dispLatch[4*digitIdx +: 4];
    blank  = 1'b0;
    segRaw = 7'h00;
    case (digitIdx)
      2'd1:    blank = (dispLatch[15:4] == 12'h000);
      2'd2:    blank = (dispLatch[15:8] == 8'h00);
      2'd3:    blank = (dispLatch[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    case (digit)
      4'd0:    segRaw = 7'h3F;
      4'd1:    segRaw = 7'h06;
      4'd2:    segRaw = 7'h5B;
      4'd3:    segRaw = 7'h4F;
      4'd4:    segRaw = 7'h66;
      4'd5:    segRaw = 7'h6D;
      4'd6:    segRaw = 7'h7D;
      4'd7:    segRaw = 7'h07;
      4'd8:    segRaw = 7'h7F;
      4'd9:    segRaw = 7'h6F;
      default: segRaw = 7'h00;
    endcase
    if (blank) segRaw = 7'h00;
  end

  assign dpOn = (digitIdx == 2'd3) && ovf;
  assign busy = (state != IDLE);
  assign an   = ~(4'b0001 << digitIdx);
  assign seg  = SEG_ACTIVE_LOW ? ~segRaw : segRaw;
  assign dp   = SEG_ACTIVE_LOW ? ~dpOn : dpOn;

endmodule

// File: tb/tb_display_mmio_ctrl.sv
// Self-checking bench for display_mmio_ctrl: stimulus pushes expected conversion
// results into a queue, a monitor pops and compares each time busy falls.
module tb_display_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] value;
  logic        busy;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  // {ovf, value, latch}
  logic [48:0] expQ[$];

  display_mmio_ctrl #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wdata(wdata),
    .value(value), .busy(busy), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed conversion (busy falling out of reset) must match the queue head
  logic prevBusy = 1'b0;
  always @(negedge clk) begin
    logic [48:0] e;
    if (!rst_n) begin
      prevBusy = 1'b0;
    end else begin
      if (prevBusy && !busy) begin
        if (expQ.size() == 0) begin
          chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          chk("mon_latch", {48'd0, dut.dispLatch}, {48'd0, e[15:0]});
          chk("mon_value", {32'd0, value}, {32'd0, e[47:16]});
          chk("mon_ovf", {63'd0, ovf}, {63'd0, e[48]});
        end
      end
      prevBusy = busy;
    end
  end

  task automatic doWrite(input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Counts negedges with busy high until it drops; bounded
  task automatic countBusy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) n++;
      else return;
    end
    chk("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic scanCheck(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic dpOn3);
    logic [6:0] s[4];
    logic [3:0] prevAn;
    logic       found;
    int         d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    found = 1'b0;
    @(negedge clk);
    prevAn = an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prevAn != 4'b1110) found = 1'b1;
      prevAn = an;
    end
    chk({tag, "_frame_start"}, {63'd0, found}, 64'd1);
    if (!found) return;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      d = i / 4;
      chk({tag, "_an"}, {60'd0, an}, {60'd0, ~(4'b0001 << d)});
      chk({tag, "_seg"}, {57'd0, seg}, {57'd0, s[d]});
      chk({tag, "_dp"}, {63'd0, dp}, {63'd0, ~((d == 3) && dpOn3)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic changed;
    logic sawFive;

    // 1. Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", {32'd0, value}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_an", {60'd0, an}, 64'b1110);
    chk("rst_seg", {57'd0, seg}, 64'h40);
    chk("rst_dp", {63'd0, dp}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    changed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || value !== 32'd0 || dut.dispLatch !== 16'h0000) changed = 1'b1;
    end
    chk("idle_stable", {63'd0, changed}, 64'd0);

    // 2. Normal write
    expQ.push_back({1'b0, 32'd1234, 16'h1234});
    doWrite(32'd1234);
    chk("w1234_value", {32'd0, value}, 64'd1234);
    chk("w1234_busy_e0", {63'd0, busy}, 64'd1);
    countBusy(n);
    chk("w1234_busy_cycles", 64'(n), 64'd15);
    scanCheck("s1234", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0);

    // 3. Saturation
    expQ.push_back({1'b1, 32'h0001_0000, 16'h9999});
    doWrite(32'h0001_0000);
    chk("sat_value", {32'd0, value}, 64'h0001_0000);
    chk("sat_ovf", {63'd0, ovf}, 64'd1);
    countBusy(n);
    chk("sat_busy_cycles", 64'(n), 64'd15);
    scanCheck("s9999", 7'h10, 7'h10, 7'h10, 7'h10, 1'b1);

    // 3b. Just at the limit: 9999 is not an overflow
    expQ.push_back({1'b0, 32'd9999, 16'h9999});
    doWrite(32'd9999);
    chk("lim_ovf", {63'd0, ovf}, 64'd0);
    countBusy(n);

    // 4. Leading zeros
    expQ.push_back({1'b0, 32'd7, 16'h0007});
    doWrite(32'd7);
    countBusy(n);
    scanCheck("s7", 7'h78, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    expQ.push_back({1'b0, 32'd0, 16'h0000});
    doWrite(32'd0);
    countBusy(n);
    scanCheck("s0", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0);

    // 4b. Inner zero is not blanked: 1005
    expQ.push_back({1'b0, 32'd1005, 16'h1005});
    doWrite(32'd1005);
    countBusy(n);
    scanCheck("s1005", 7'h12, 7'h40, 7'h40, 7'h79, 1'b0);

    // 5. Write while busy: 5 at E0, 42 at E5, only 42 completes
    expQ.push_back({1'b0, 32'd42, 16'h0042});
    doWrite(32'd5);
    repeat (4) @(posedge clk);
    doWrite(32'd42);
    chk("wwb_value", {32'd0, value}, 64'd42);
    chk("wwb_busy_e5", {63'd0, busy}, 64'd1);
    sawFive = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.dispLatch == 16'h0005) sawFive = 1'b1;
      if (busy) n++;
      else break;
    end
    chk("wwb_busy_after_e5", 64'(n), 64'd25);
    chk("wwb_no_5_latched", {63'd0, sawFive}, 64'd0);

    // 6. Reset mid-conversion
    doWrite(32'd8888);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_value", {32'd0, value}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_ovf", {63'd0, ovf}, 64'd0);
    chk("mrst_an", {60'd0, an}, 64'b1110);
    chk("mrst_seg", {57'd0, seg}, 64'h40);
    chk("mrst_dp", {63'd0, dp}, 64'd1);
    chk("mrst_latch", {48'd0, dut.dispLatch}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back({1'b0, 32'd8888, 16'h8888});
    doWrite(32'd8888);
    countBusy(n);
    chk("w8888_busy_cycles", 64'(n), 64'd15);
    scanCheck("s8888", 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
